dp_ram_init: RTL and testbench

DP_RAM_INIT -- requirements
Module: dp_ram_init

---
 rtl/dp_ram_init.sv | 143 ++++++++++++++
 tb/tb_dp_ram_init.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_init.sv
// Dual-port byte-writable RAM that sweeps init_value into every word after reset.
// Ports are gated off until the sweep finishes; reads are write-first across both ports.
module dp_ram_init #(
    parameter int unsigned addr_bits = 8,
    parameter int unsigned data_bits = 32,
    parameter logic [data_bits-1:0] init_value = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   ready,
    input  logic [addr_bits-1:0]   a_addr,
    input  logic [data_bits-1:0]   a_din,
    input  logic [data_bits/8-1:0] a_be,
    input  logic                   a_wr_en,
    input  logic                   a_rd_en,
    output logic [data_bits-1:0]   a_dout,
    output logic                   a_valid,
    input  logic [addr_bits-1:0]   b_addr,
    input  logic [data_bits-1:0]   b_din,
    input  logic [data_bits/8-1:0] b_be,
    input  logic                   b_wr_en,
    input  logic                   b_rd_en,
    output logic [data_bits-1:0]   b_dout,
    output logic                   b_valid
);

    localparam int unsigned depth     = 2 ** addr_bits;
    localparam int unsigned num_bytes = data_bits / 8;
    localparam logic [addr_bits-1:0] last_addr = '1;

    localparam logic [0:0] st_init  = 1'b0;
    localparam logic [0:0] st_ready = 1'b1;

    logic [data_bits-1:0] mem [depth];

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic [addr_bits-1:0] cnt;
    logic [addr_bits-1:0] cnt_next;
    logic                 ready_next;
    logic                 sweep_we_c;
    logic                 a_we_c;
    logic                 b_we_c;
    logic [data_bits-1:0] a_word_c;
    logic [data_bits-1:0] b_word_c;

    // State, sweep counter and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_init;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= ready_next;
        end
    end

    // Sweep one address per edge; the counter parks on the last address
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = ready;
        sweep_we_c = 1'b0;
        case (state)
            st_init: begin
                sweep_we_c = rst_n;
                if (cnt == last_addr) begin
                    state_next = st_ready;
                    ready_next = 1'b1;
                end else begin
                    cnt_next = cnt + addr_bits'(1);
                end
            end
            st_ready: begin
                ready_next = 1'b1;
            end
            default: begin
                state_next = st_init;
                cnt_next   = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    assign a_we_c = ready & a_wr_en;
    assign b_we_c = ready & b_wr_en;

    // Post-edge word at each port address: B bytes first, A overrides on overlap
    always_comb begin
        a_word_c = mem[a_addr];
        b_word_c = mem[b_addr];
        for (int i = 0; i < int'(num_bytes); i++) begin
            if (b_we_c && b_be[i] && (b_addr == a_addr)) begin
                a_word_c[8*i +: 8] = b_din[8*i +: 8];
            end
            if (a_we_c && a_be[i]) begin
                a_word_c[8*i +: 8] = a_din[8*i +: 8];
            end
            if (b_we_c && b_be[i]) begin
                b_word_c[8*i +: 8] = b_din[8*i +: 8];
            end
            if (a_we_c && a_be[i] && (a_addr == b_addr)) begin
                b_word_c[8*i +: 8] = a_din[8*i +: 8];
            end
        end
    end

    // Storage has no reset; only the sweep reinitialises it
    always_ff @(posedge clk) begin
        if (sweep_we_c) begin
            mem[cnt] <= init_value;
        end else begin
            if (a_we_c) begin
                mem[a_addr] <= a_word_c;
            end
            if (b_we_c) begin
                mem[b_addr] <= b_word_c;
            end
        end
    end

    // Registered read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_dout  <= '0;
            b_dout  <= '0;
        end else begin
            a_valid <= ready & a_rd_en;
            b_valid <= ready & b_rd_en;
            if (ready && a_rd_en) begin
                a_dout <= a_word_c;
            end
            if (ready && b_rd_en) begin
                b_dout <= b_word_c;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_init.sv
// Bench for dp_ram_init: directed init/reset/collision steps plus randomized
// dual-port traffic checked against an array-based memory model.
module tb_dp_ram_init;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [3:0]  a_be, b_be;
    logic        a_wr_en, a_rd_en, b_wr_en, b_rd_en;
    logic [31:0] a_dout, b_dout;
    logic        a_valid, b_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    logic [31:0] nm [16];
    logic [31:0] exp_a, exp_b;

    dp_ram_init #(
        .addr_bits (4),
        .data_bits (32),
        .init_value(32'hDEADBEEF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ready  (ready),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_be   (a_be),
        .a_wr_en(a_wr_en),
        .a_rd_en(a_rd_en),
        .a_dout (a_dout),
        .a_valid(a_valid),
        .b_addr (b_addr),
        .b_din  (b_din),
        .b_be   (b_be),
        .b_wr_en(b_wr_en),
        .b_rd_en(b_rd_en),
        .b_dout (b_dout),
        .b_valid(b_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0; a_be = '0; b_be = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    // Wait for ready after release; returns number of edges seen (bounded)
    task automatic wait_ready(output int edges);
        edges = 0;
        for (int e = 0; e < 40; e++) begin
            step();
            edges++;
            chk("valid_a_while_not_ready", 32'(a_valid), 32'd0);
            chk("valid_b_while_not_ready", 32'(b_valid), 32'd0);
            if (ready) break;
        end
    endtask

    // Read every word on both ports (B in reverse order) and compare to the model
    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            idle();
            a_addr = 4'(i); a_rd_en = 1'b1;
            b_addr = 4'(15 - i); b_rd_en = 1'b1;
            step();
            chk({tag, "_a_dout"}, a_dout, model[i]);
            chk({tag, "_a_valid"}, 32'(a_valid), 32'd1);
            chk({tag, "_b_dout"}, b_dout, model[15 - i]);
            chk({tag, "_b_valid"}, 32'(b_valid), 32'd1);
        end
        idle();
        step();
        chk({tag, "_a_valid_drop"}, 32'(a_valid), 32'd0);
        chk({tag, "_a_dout_hold"}, a_dout, model[15]);
    endtask

    initial begin
        int edges;
        logic aw, ar, bw, br;

        idle();
        rst_n = 1'b0;
        a_wr_en = 1'b1; a_rd_en = 1'b1; a_addr = 4'd2; a_be = 4'hF;
        repeat (3) step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_dout", a_dout, 32'd0);
        chk("rst_b_dout", b_dout, 32'd0);

        // Release with port A writing 0 to addr 2 and reading throughout the sweep
        rst_n = 1'b1;
        b_wr_en = 1'b1; b_rd_en = 1'b1; b_addr = 4'd9; b_din = 32'h12121212; b_be = 4'hF;
        wait_ready(edges);
        chk("sweep_edges", 32'(edges), 32'd16);
        chk("sweep_a_dout_unchanged", a_dout, 32'd0);
        for (int i = 0; i < 16; i++) model[i] = 32'hDEADBEEF;
        read_all("init");

        // Partial byte write then read back
        idle();
        a_addr = 4'd3; a_din = 32'h11223344; a_be = 4'b0101; a_wr_en = 1'b1;
        step();
        model[3] = merge(model[3], 32'h11223344, 4'b0101);
        idle();
        a_addr = 4'd3; a_rd_en = 1'b1;
        step();
        chk("be_write_a_dout", a_dout, 32'hDE22BE44);

        // Same-address dual write, byte-level arbitration
        idle();
        a_addr = 4'd5; a_din = 32'hAAAAAAAA; a_be = 4'b1100; a_wr_en = 1'b1;
        b_addr = 4'd5; b_din = 32'hBBBBBBBB; b_be = 4'b0110; b_wr_en = 1'b1;
        step();
        model[5] = 32'hAAAABBEF;
        idle();
        a_addr = 4'd5; a_rd_en = 1'b1; b_addr = 4'd5; b_rd_en = 1'b1;
        step();
        chk("collide_a_dout", a_dout, 32'hAAAABBEF);
        chk("collide_b_dout", b_dout, 32'hAAAABBEF);

        // Cross-port read-during-write
        idle();
        a_addr = 4'd7; a_din = 32'h12345678; a_be = 4'hF; a_wr_en = 1'b1;
        b_addr = 4'd7; b_rd_en = 1'b1;
        step();
        model[7] = 32'h12345678;
        chk("xport_b_dout", b_dout, 32'h12345678);
        chk("xport_b_valid", 32'(b_valid), 32'd1);

        // Randomized traffic, addresses biased toward collisions
        exp_a = a_dout;
        exp_b = b_dout;
        for (int n = 0; n < 400; n++) begin
            aw = 1'($urandom_range(0, 1)); ar = 1'($urandom_range(0, 1));
            bw = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
            a_addr = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            b_addr = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            a_din = $urandom; b_din = $urandom;
            a_be = 4'($urandom_range(0, 15)); b_be = 4'($urandom_range(0, 15));
            a_wr_en = aw; a_rd_en = ar; b_wr_en = bw; b_rd_en = br;
            nm = model;
            if (bw) nm[b_addr] = merge(nm[b_addr], b_din, b_be);
            if (aw) nm[a_addr] = merge(nm[a_addr], a_din, a_be);
            if (ar) exp_a = nm[a_addr];
            if (br) exp_b = nm[b_addr];
            step();
            model = nm;
            chk("rand_a_valid", 32'(a_valid), 32'(ar));
            chk("rand_b_valid", 32'(b_valid), 32'(br));
            chk("rand_a_dout", a_dout, exp_a);
            chk("rand_b_dout", b_dout, exp_b);
        end
        idle();
        read_all("rand");

        // Reset mid-sweep: outputs clear at once, sweep restarts from 0
        a_addr = 4'd0; a_din = 32'h00000055; a_be = 4'hF; a_wr_en = 1'b1; a_rd_en = 1'b1;
        step();
        chk("pre_rst_a_dout", a_dout, 32'h00000055);
        idle();
        rst_n = 1'b0;
        #1;
        chk("async_rst_a_dout", a_dout, 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("mid_sweep_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_b_dout", b_dout, 32'd0);
        chk("mid_rst_a_valid", 32'(a_valid), 32'd0);
        repeat (2) step();
        chk("mid_rst_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        wait_ready(edges);
        chk("resweep_edges", 32'(edges), 32'd16);
        for (int i = 0; i < 16; i++) model[i] = 32'hDEADBEEF;
        read_all("resweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
